// File: rtl/synthesijer_fadd32_core.sv
// IEEE-754 single-precision adder with AXI4-Stream style operand/result ports.
// Five register ranks give a fixed 4-cycle issue-to-result latency; RNE rounding, FTZ/DAZ.
module synthesijer_fadd32_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_a_tvalid,
    input  logic [31:0] s_axis_b_tdata,
    input  logic        s_axis_b_tvalid,
    output logic        m_axis_result_tvalid,
    output logic [31:0] m_axis_result_tdata
);

    typedef struct packed {
        logic vld;
        logic nan;
        logic inf;
        logic inf_sign;
        logic sign;      // sign of the larger-magnitude operand
        logic zero_sign; // sign used when the sum is exactly zero
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic        sub;
        logic [7:0]  x_exp;
        logic [7:0]  y_exp;
        logic [23:0] x_man;
        logic [23:0] y_man;
    } st1_t;

    typedef struct packed {
        ctl_t        ctl;
        logic        sub;
        logic [7:0]  x_exp;
        logic [26:0] x_ext;
        logic [26:0] y_ext;
    } st2_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [7:0]  x_exp;
        logic [27:0] sum;
        logic [4:0]  lzc;
    } st3_t;

    typedef struct packed {
        ctl_t               ctl;
        logic               zero;
        logic signed [9:0]  exp;
        logic [26:0]        norm;
    } st4_t;

    st1_t s1_d, s1_q;
    st2_t s2_d, s2_q;
    st3_t s3_d, s3_q;
    st4_t s4_d, s4_q;
    logic        tvalid_d, tvalid_q;
    logic [31:0] tdata_d, tdata_q;

    logic        a_nan, a_inf, b_nan, b_inf, swap;
    logic [30:0] a_mag, b_mag, x_mag, y_mag;

    always_comb begin
        a_nan = (s_axis_a_tdata[30:23] == 8'hFF) && (s_axis_a_tdata[22:0] != 23'd0);
        a_inf = (s_axis_a_tdata[30:23] == 8'hFF) && (s_axis_a_tdata[22:0] == 23'd0);
        b_nan = (s_axis_b_tdata[30:23] == 8'hFF) && (s_axis_b_tdata[22:0] != 23'd0);
        b_inf = (s_axis_b_tdata[30:23] == 8'hFF) && (s_axis_b_tdata[22:0] == 23'd0);
        // Subnormals become zero before the magnitude compare
        a_mag = (s_axis_a_tdata[30:23] == 8'h00) ? 31'd0 : s_axis_a_tdata[30:0];
        b_mag = (s_axis_b_tdata[30:23] == 8'h00) ? 31'd0 : s_axis_b_tdata[30:0];
        swap  = b_mag > a_mag;
        x_mag = swap ? b_mag : a_mag;
        y_mag = swap ? a_mag : b_mag;

        s1_d               = '0;
        s1_d.ctl.vld       = s_axis_a_tvalid && s_axis_b_tvalid;
        s1_d.ctl.nan       = a_nan || b_nan ||
                             (a_inf && b_inf && (s_axis_a_tdata[31] != s_axis_b_tdata[31]));
        s1_d.ctl.inf       = a_inf || b_inf;
        s1_d.ctl.inf_sign  = a_inf ? s_axis_a_tdata[31] : s_axis_b_tdata[31];
        s1_d.ctl.sign      = swap ? s_axis_b_tdata[31] : s_axis_a_tdata[31];
        s1_d.ctl.zero_sign = s_axis_a_tdata[31] && s_axis_b_tdata[31];
        s1_d.sub           = s_axis_a_tdata[31] ^ s_axis_b_tdata[31];
        s1_d.x_exp         = x_mag[30:23];
        s1_d.y_exp         = y_mag[30:23];
        s1_d.x_man         = (x_mag[30:23] == 8'h00) ? 24'd0 : {1'b1, x_mag[22:0]};
        s1_d.y_man         = (y_mag[30:23] == 8'h00) ? 24'd0 : {1'b1, y_mag[22:0]};
    end

    logic [7:0]  exp_diff;
    logic [4:0]  shamt;
    logic [26:0] y_full, y_shr;
    logic        sticky;

    always_comb begin
        exp_diff   = s1_q.x_exp - s1_q.y_exp;
        shamt      = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
        y_full     = {s1_q.y_man, 3'b000};
        y_shr      = y_full >> shamt;
        sticky     = (y_shr << shamt) != y_full;
        s2_d       = '0;
        s2_d.ctl   = s1_q.ctl;
        s2_d.sub   = s1_q.sub;
        s2_d.x_exp = s1_q.x_exp;
        s2_d.x_ext = {s1_q.x_man, 3'b000};
        s2_d.y_ext = {y_shr[26:1], y_shr[0] | sticky};
    end

    always_comb begin
        s3_d       = '0;
        s3_d.ctl   = s2_q.ctl;
        s3_d.x_exp = s2_q.x_exp;
        // |X| >= |Y| so the difference never goes negative
        s3_d.sum   = s2_q.sub ? ({1'b0, s2_q.x_ext} - {1'b0, s2_q.y_ext})
                              : ({1'b0, s2_q.x_ext} + {1'b0, s2_q.y_ext});
        s3_d.lzc   = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (s3_d.sum[i]) s3_d.lzc = 5'(27 - i);
        end
    end

    logic [4:0]  lshift;
    logic [26:0] shl;

    always_comb begin
        s4_d      = '0;
        s4_d.ctl  = s3_q.ctl;
        s4_d.zero = s3_q.sum == 28'd0;
        lshift    = s3_q.lzc - 5'd1;
        shl       = s3_q.sum[26:0] << lshift;
        if (s3_q.sum[27]) begin
            s4_d.norm = {s3_q.sum[27:2], s3_q.sum[1] | s3_q.sum[0]};
            s4_d.exp  = $signed({2'b00, s3_q.x_exp}) + 10'sd1;
        end else begin
            s4_d.norm = shl;
            s4_d.exp  = $signed({2'b00, s3_q.x_exp}) - $signed({5'b00000, lshift});
        end
    end

    logic               round_up;
    logic [24:0]        man_rnd;
    logic signed [9:0]  exp_rnd;
    logic [22:0]        frac;

    always_comb begin
        round_up = s4_q.norm[2] && (s4_q.norm[1] || s4_q.norm[0] || s4_q.norm[3]);
        man_rnd  = {1'b0, s4_q.norm[26:3]} + {24'd0, round_up};
        exp_rnd  = s4_q.exp + $signed({9'd0, man_rnd[24]});
        frac     = man_rnd[24] ? man_rnd[23:1] : man_rnd[22:0];
        tvalid_d = s4_q.ctl.vld;
        tdata_d  = tdata_q;
        if (s4_q.ctl.vld) begin
            if (s4_q.ctl.nan)            tdata_d = 32'h7FC0_0000;
            else if (s4_q.ctl.inf)       tdata_d = {s4_q.ctl.inf_sign, 8'hFF, 23'd0};
            else if (s4_q.zero)          tdata_d = {s4_q.ctl.zero_sign, 31'd0};
            else if (exp_rnd > 10'sd254) tdata_d = {s4_q.ctl.sign, 8'hFF, 23'd0};
            else if (exp_rnd < 10'sd1)   tdata_d = {s4_q.ctl.sign, 31'd0};
            else                         tdata_d = {s4_q.ctl.sign, exp_rnd[7:0], frac};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            s4_q     <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= 32'h0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            s4_q     <= s4_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    assign m_axis_result_tvalid = tvalid_q;
    assign m_axis_result_tdata  = tdata_q;

endmodule

// File: tb/tb_synthesijer_fadd32_core.sv
// Scoreboard bench for synthesijer_fadd32_core; reference sums come from double-precision
// arithmetic rounded to single with RNE and flush-to-zero.
module tb_synthesijer_fadd32_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid;
    logic        r_valid;
    logic [31:0] r_data;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expv;
        int          k;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    synthesijer_fadd32_core dut (
        .clk                  (clk),
        .reset                (reset),
        .s_axis_a_tdata       (a_data),
        .s_axis_a_tvalid      (a_valid),
        .s_axis_b_tdata       (b_data),
        .s_axis_b_tvalid      (b_valid),
        .m_axis_result_tvalid (r_valid),
        .m_axis_result_tdata  (r_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] to_dbl(input logic [31:0] f);
        logic [10:0] de;
        if (f[30:23] == 8'h00) return {f[31], 63'd0};
        de = {3'b000, f[30:23]} + 11'd896;
        return {f[31], de, f[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, up;
        real         r;
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return 32'h7FC0_0000;
        if (a_inf) return a;
        if (b_inf) return b;
        // Double holds the float sum with enough spare precision that re-rounding is exact
        r = $bitstoreal(to_dbl(a)) + $bitstoreal(to_dbl(b));
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e  = int'(d[62:52]) - 896;
        m  = {2'b01, d[51:29]};
        up = d[28] && ((d[27:0] != 28'd0) || d[29]);
        m  = m + 25'(up);
        if (m[24]) begin
            e++;
            m = m >> 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e < 1) return {d[63], 31'd0};
        return {d[63], 8'(e), m[22:0]};
    endfunction

    always @(negedge clk) begin
        if (r_valid === 1'b1) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_tvalid cycle=%0d tdata=%h (no result was due)",
                         cyc, r_data);
            end else begin
                mon_e = sb.pop_front();
                if (r_data !== mon_e.expv)
                    $display("FAIL result a=%h b=%h got=%h expected=%h",
                             mon_e.a, mon_e.b, r_data, mon_e.expv);
                else
                    n_pass++;
                n_total++;
                if (cyc !== mon_e.k + 4)
                    $display("FAIL latency a=%h b=%h got_cycle=%0d expected_cycle=%0d",
                             mon_e.a, mon_e.b, cyc, mon_e.k + 4);
                else
                    n_pass++;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        sb_t e;
        @(posedge clk);
        #1;
        a_data  = a;
        b_data  = b;
        a_valid = 1'b1;
        b_valid = 1'b1;
        e.a     = a;
        e.b     = b;
        e.expv  = expv;
        e.k     = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = 32'h0;
        b_data  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (r_valid !== 1'b0) $display("FAIL reset_tvalid got=%b expected=0", r_valid);
        else n_pass++;
        n_total++;
        if (r_data !== 32'h0) $display("FAIL reset_tdata got=%h expected=00000000", r_data);
        else n_pass++;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (r_valid !== 1'b0) $display("FAIL post_reset_tvalid got=%b expected=0", r_valid);
        else n_pass++;
    endtask

    task automatic test_basic();
        issue(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        idle();
        wait_drain();
        n_total++;
        if (sb.size() !== 0) $display("FAIL basic_drain pending=%0d expected=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_rounding();
        issue(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
        issue(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
        idle();
        wait_drain();
        n_total++;
        if (sb.size() !== 0) $display("FAIL rounding_drain pending=%0d expected=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_specials();
        logic [31:0] va [13];
        logic [31:0] vb [13];
        logic [31:0] ve [13];
        va = '{32'h7F80_0000, 32'h3F80_0000, 32'h8000_0000, 32'h7F7F_FFFF, 32'h0040_0000,
               32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0001, 32'h807F_FFFF, 32'h8080_0001,
               32'h0080_0001, 32'hFF7F_FFFF, 32'h3F80_0000};
        vb = '{32'hFF80_0000, 32'hBF80_0000, 32'h8000_0000, 32'h7F7F_FFFF, 32'h0000_0001,
               32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h8000_0000, 32'h0080_0000,
               32'h8080_0000, 32'hFF7F_FFFF, 32'h0000_0000};
        ve = '{32'h7FC0_0000, 32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0000,
               32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h8000_0000,
               32'h0000_0000, 32'hFF80_0000, 32'h3F80_0000};
        for (int i = 0; i < 13; i++) issue(va[i], vb[i], ve[i]);
        idle();
        wait_drain();
        n_total++;
        if (sb.size() !== 0) $display("FAIL specials_drain pending=%0d expected=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_handshake();
        @(posedge clk);
        #1;
        a_data  = 32'h3F80_0000;
        b_data  = 32'h3F80_0000;
        a_valid = 1'b1;
        b_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_total++;
            if (r_valid !== 1'b0) $display("FAIL lone_valid cycle=%0d tvalid=%b expected=0",
                                           cyc, r_valid);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        for (int i = 0; i < 200; i++) begin
            a = $urandom();
            b = $urandom();
            case (i % 4)
                1: b[30:23] = a[30:23] - 8'(i % 3);
                2: b = {~a[31], a[30:4], b[3:0]};
                3: b[30:23] = a[30:23] - 8'(23 + i % 3);
                default: ;
            endcase
            if (i % 50 == 7) b = a ^ 32'h8000_0000;
            issue(a, b, ref_add(a, b));
        end
        idle();
        wait_drain();
        n_total++;
        if (sb.size() !== 0) $display("FAIL b2b_drain pending=%0d expected=0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        issue(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        idle();
        wait_drain();
        @(posedge clk);
        #1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = 32'h3F80_0000 + 32'(i);
            b_data = 32'h3F80_0000;
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_total++;
        if (r_valid !== 1'b0) $display("FAIL async_reset_tvalid got=%b expected=0", r_valid);
        else n_pass++;
        n_total++;
        if (r_data !== 32'h0) $display("FAIL async_reset_tdata got=%h expected=00000000", r_data);
        else n_pass++;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_total++;
            if (r_valid !== 1'b0) $display("FAIL flushed_op cycle=%0d tvalid=%b expected=0",
                                           cyc, r_valid);
            else n_pass++;
        end
        issue(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        idle();
        wait_drain();
        n_total++;
        if (sb.size() !== 0) $display("FAIL fresh_op_drain pending=%0d expected=0", sb.size());
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d expected completion before time limit", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_handshake();
        test_back_to_back();
        test_reset_midflight();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
